// File: rtl/irrigation_sequencer.sv
// Runs one watering cycle: loads the run time, counts it down in BCD and drives the valve.
// Ports: clk, clear_n, tick, start, mode, abort, sensors -> valves, status flags, BCD count, state.
module irrigation_sequencer #(
    parameter int SPRINKLER_MIN = 5,
    parameter int DRIP_MIN      = 9
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       tick,
    input  logic       start,
    input  logic       mode,
    input  logic       abort,
    input  logic       water_low,
    input  logic       soil_wet,
    input  logic       rain,
    output logic       valve_sprinkler,
    output logic       valve_drip,
    output logic       busy,
    output logic       done,
    output logic       skipped,
    output logic       fault,
    output logic [3:0] min_bcd,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_units,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_RUN   = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [3:0] SPR_L  = 4'(SPRINKLER_MIN);
    localparam logic [3:0] DRIP_L = 4'(DRIP_MIN);

    state_t     state_q, state_d;
    logic       mode_q, mode_d;
    logic       skipped_q, skipped_d;
    logic [3:0] min_q, min_d;
    logic [2:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic       vs_q, vs_d;
    logic       vd_q, vd_d;

    logic       cnt_zero;
    logic       cnt_one;

    assign cnt_zero = (min_q == 4'd0) && (tens_q == 3'd0) && (units_q == 4'd0);
    assign cnt_one  = (min_q == 4'd0) && (tens_q == 3'd0) && (units_q == 4'd1);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        skipped_d = skipped_q;
        min_d     = min_q;
        tens_d    = tens_q;
        units_d   = units_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CHECK;
                    mode_d    = mode;
                    min_d     = mode ? DRIP_L : SPR_L;
                    tens_d    = 3'd0;
                    units_d   = 4'd0;
                    skipped_d = 1'b0;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d = S_IDLE;
                    min_d   = 4'd0;
                    tens_d  = 3'd0;
                    units_d = 4'd0;
                end else if (water_low) begin
                    state_d = S_FAULT;
                end else if (soil_wet || (rain && !mode_q)) begin
                    state_d   = S_DONE;
                    skipped_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    min_d   = 4'd0;
                    tens_d  = 3'd0;
                    units_d = 4'd0;
                end else if (water_low) begin
                    state_d = S_FAULT;
                end else if (soil_wet) begin
                    state_d = S_DONE;
                end else if (rain && !mode_q) begin
                    state_d = S_HOLD;
                end else if (tick) begin
                    // 0:00 is never decremented; the last tick lands on DONE
                    if (cnt_zero) begin
                        state_d = S_DONE;
                    end else begin
                        if (units_q != 4'd0) begin
                            units_d = units_q - 4'd1;
                        end else begin
                            units_d = 4'd9;
                            if (tens_q != 3'd0) begin
                                tens_d = tens_q - 3'd1;
                            end else begin
                                tens_d = 3'd5;
                                min_d  = min_q - 4'd1;
                            end
                        end
                        if (cnt_one) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    min_d   = 4'd0;
                    tens_d  = 3'd0;
                    units_d = 4'd0;
                end else if (water_low) begin
                    state_d = S_FAULT;
                end else if (!rain) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    min_d   = 4'd0;
                    tens_d  = 3'd0;
                    units_d = 4'd0;
                end else if (start && !water_low) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Valves follow the next state so they are registered yet aligned with RUN
        vs_d = (state_d == S_RUN) && !mode_d;
        vd_d = (state_d == S_RUN) && mode_d;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            skipped_q <= 1'b0;
            min_q     <= 4'd0;
            tens_q    <= 3'd0;
            units_q   <= 4'd0;
            vs_q      <= 1'b0;
            vd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            skipped_q <= skipped_d;
            min_q     <= min_d;
            tens_q    <= tens_d;
            units_q   <= units_d;
            vs_q      <= vs_d;
            vd_q      <= vd_d;
        end
    end

    assign valve_sprinkler = vs_q;
    assign valve_drip      = vd_q;
    assign busy            = (state_q == S_CHECK) || (state_q == S_RUN) ||
                             (state_q == S_HOLD);
    assign done            = (state_q == S_DONE);
    assign fault           = (state_q == S_FAULT);
    assign skipped         = skipped_q;
    assign min_bcd         = min_q;
    assign sec_tens        = tens_q;
    assign sec_units       = units_q;
    assign state           = state_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed bench for irrigation_sequencer (SPRINKLER_MIN=1, DRIP_MIN=9).
// Drives inputs 1 time unit after each rising edge and checks there too.
module tb_irrigation_sequencer;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       abort = 1'b0;
    logic       water_low = 1'b0;
    logic       soil_wet = 1'b0;
    logic       rain = 1'b0;
    logic       valve_sprinkler;
    logic       valve_drip;
    logic       busy;
    logic       done;
    logic       skipped;
    logic       fault;
    logic [3:0] min_bcd;
    logic [2:0] sec_tens;
    logic [3:0] sec_units;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    irrigation_sequencer #(
        .SPRINKLER_MIN(1),
        .DRIP_MIN(9)
    ) dut (
        .clk(clk),
        .clear_n(clear_n),
        .tick(tick),
        .start(start),
        .mode(mode),
        .abort(abort),
        .water_low(water_low),
        .soil_wet(soil_wet),
        .rain(rain),
        .valve_sprinkler(valve_sprinkler),
        .valve_drip(valve_drip),
        .busy(busy),
        .done(done),
        .skipped(skipped),
        .fault(fault),
        .min_bcd(min_bcd),
        .sec_tens(sec_tens),
        .sec_units(sec_units),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int m, input int t, input int u);
        return 32'((m << 8) | (t << 4) | u);
    endfunction

    function automatic logic [31:0] cnt_s(input int r);
        return cnt(r / 60, (r % 60) / 10, r % 10);
    endfunction

    function automatic logic [31:0] dut_cnt();
        return 32'({min_bcd, 1'b0, sec_tens, sec_units});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (done) done_cnt++;
    endtask

    task automatic pulse_tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    task automatic launch(input logic m);
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
        mode  = 1'b0;
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("rst_state", 32'(state), 0);
        chk("rst_valves", 32'({valve_sprinkler, valve_drip}), 0);
        chk("rst_count", dut_cnt(), cnt(0, 0, 0));
        chk("rst_flags", 32'({busy, done, skipped, fault}), 0);
        clear_n = 1'b1;
        step();

        // sprinkler full cycle, 1 minute
        launch(1'b0);
        chk("spr_check_state", 32'(state), 1);
        chk("spr_check_valve", 32'(valve_sprinkler), 0);
        chk("spr_load", dut_cnt(), cnt(1, 0, 0));
        step();
        chk("spr_run_state", 32'(state), 2);
        chk("spr_valve_on", 32'({valve_sprinkler, valve_drip}), 2);
        chk("spr_busy", 32'(busy), 1);
        done_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            pulse_tick(1);
            chk("spr_count", dut_cnt(), cnt_s(59 - i));
            if (i < 59) chk("spr_running", 32'(state), 2);
        end
        chk("spr_end_state", 32'(state), 4);
        chk("spr_done", 32'(done), 1);
        chk("spr_end_valve", 32'(valve_sprinkler), 0);
        step();
        chk("spr_idle", 32'(state), 0);
        chk("spr_done_once", 32'(done_cnt), 1);
        chk("spr_skipped", 32'(skipped), 0);
        chk("spr_hold_count", dut_cnt(), cnt(0, 0, 0));

        // drip borrow, rain ignored, abort
        launch(1'b1);
        chk("drip_load", dut_cnt(), cnt(9, 0, 0));
        step();
        chk("drip_valve", 32'({valve_sprinkler, valve_drip}), 1);
        pulse_tick(1);
        chk("drip_859", dut_cnt(), cnt(8, 5, 9));
        pulse_tick(9);
        chk("drip_850", dut_cnt(), cnt(8, 5, 0));
        pulse_tick(1);
        chk("drip_849", dut_cnt(), cnt(8, 4, 9));
        rain = 1'b1;
        pulse_tick(1);
        chk("drip_rain_cnt", dut_cnt(), cnt(8, 4, 8));
        chk("drip_rain_state", 32'(state), 2);
        chk("drip_rain_valve", 32'(valve_drip), 1);
        rain = 1'b0;
        done_cnt = 0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_state", 32'(state), 0);
        chk("abort_count", dut_cnt(), cnt(0, 0, 0));
        chk("abort_valves", 32'({valve_sprinkler, valve_drip}), 0);
        step();
        chk("abort_no_done", 32'(done_cnt), 0);

        // rain pause in sprinkler mode
        launch(1'b0);
        step();
        pulse_tick(20);
        chk("rain_pre", dut_cnt(), cnt(0, 4, 0));
        rain = 1'b1;
        step();
        chk("hold_state", 32'(state), 3);
        chk("hold_valve", 32'(valve_sprinkler), 0);
        chk("hold_busy", 32'(busy), 1);
        pulse_tick(20);
        chk("hold_count", dut_cnt(), cnt(0, 4, 0));
        rain = 1'b0;
        step();
        chk("resume_state", 32'(state), 2);
        pulse_tick(1);
        chk("resume_count", dut_cnt(), cnt(0, 3, 9));
        chk("resume_valve", 32'(valve_sprinkler), 1);
        rain = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        rain = 1'b0;
        chk("rain_tick_state", 32'(state), 3);
        chk("rain_tick_lost", dut_cnt(), cnt(0, 3, 9));
        step();

        // fault at 0:30
        pulse_tick(9);
        chk("fault_pre", dut_cnt(), cnt(0, 3, 0));
        water_low = 1'b1;
        step();
        chk("fault_state", 32'(state), 5);
        chk("fault_flag", 32'(fault), 1);
        chk("fault_valve", 32'(valve_sprinkler), 0);
        chk("fault_count", dut_cnt(), cnt(0, 3, 0));
        start = 1'b1;
        step();
        start = 1'b0;
        chk("fault_stay", 32'(state), 5);
        water_low = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("fault_ack", 32'(state), 0);
        chk("fault_clr", 32'(fault), 0);
        step();
        chk("fault_no_launch", 32'(state), 0);
        launch(1'b0);
        chk("relaunch_state", 32'(state), 1);
        chk("relaunch_count", dut_cnt(), cnt(1, 0, 0));
        step();
        chk("relaunch_run", 32'(valve_sprinkler), 1);

        // async reset mid-run
        #2;
        clear_n = 1'b0;
        #1;
        chk("arst_valve", 32'(valve_sprinkler), 0);
        chk("arst_state", 32'(state), 0);
        step();
        clear_n = 1'b1;
        step();

        // skip on wet soil
        soil_wet = 1'b1;
        launch(1'b0);
        chk("skip_check", 32'(state), 1);
        chk("skip_v0", 32'({valve_sprinkler, valve_drip}), 0);
        step();
        chk("skip_done_state", 32'(state), 4);
        chk("skip_done", 32'(done), 1);
        chk("skip_flag", 32'(skipped), 1);
        chk("skip_v1", 32'({valve_sprinkler, valve_drip}), 0);
        soil_wet = 1'b0;
        step();
        chk("skip_idle", 32'(state), 0);
        chk("skip_held", 32'(skipped), 1);
        chk("skip_v2", 32'({valve_sprinkler, valve_drip}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
